game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 155 +++++++++++++++
 tb/tb_game_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game flow controller: idle/restart/play/pause/game-over sequencing, lives and score
// bookkeeping, a free-running game tick and periodic enemy-fire requests.
module game_controller #(
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned FIRE_PERIOD = 90,
  parameter int unsigned RESTART_LEN = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       inimigo_vivo,
  input  logic       nave_atingida,
  output logic       pausa,
  output logic       reiniciarJogo,
  output logic       game_tick,
  output logic       disparo_inimigo,
  output logic [1:0] vidas,
  output logic [7:0] pontos,
  output logic [2:0] estado
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TickW-1:0] TickLast    = TickW'(TICK_DIV - 1);
  localparam logic [7:0]       FireLast    = 8'(FIRE_PERIOD - 1);
  localparam logic [3:0]       RestartLast = 4'(RESTART_LEN - 1);
  localparam logic [1:0]       LivesInit   = 2'(LIVES_INIT);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRestart  = 3'd1;
  localparam logic [2:0] StPlay     = 3'd2;
  localparam logic [2:0] StPause    = 3'd3;
  localparam logic [2:0] StGameOver = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick_q;
  logic [7:0]       fire_cnt_q, fire_cnt_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic [1:0]       vidas_q, vidas_d;
  logic [7:0]       pontos_q, pontos_d;
  logic             start_q, pause_q, vivo_q;

  logic start_edge, pause_edge, vivo_fall, tick_wrap, fire_now;

  assign start_edge = btn_start & ~start_q;
  assign pause_edge = btn_pause & ~pause_q;
  assign vivo_fall  = ~inimigo_vivo & vivo_q;
  assign tick_wrap  = (tick_cnt_q == TickLast);

  // Free-running in every state; the strobe is registered so it appears on the wrap cycle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + TickW'(1);
      tick_q     <= tick_wrap;
    end
  end

  always_comb begin
    state_d    = state_q;
    fire_cnt_d = fire_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    vidas_d    = vidas_q;
    pontos_d   = pontos_q;
    fire_now   = 1'b0;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_edge) begin
          state_d   = StRestart;
          rst_cnt_d = '0;
          vidas_d   = LivesInit;
          pontos_d  = '0;
        end
      end
      StRestart: begin
        if (rst_cnt_q == RestartLast) begin
          state_d    = StPlay;
          fire_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      StPlay: begin
        if (tick_q) begin
          if (fire_cnt_q == FireLast) begin
            fire_cnt_d = '0;
            fire_now   = inimigo_vivo;
          end else begin
            fire_cnt_d = fire_cnt_q + 8'd1;
          end
        end
        if (vivo_fall && (pontos_q != 8'hFF)) begin
          pontos_d = pontos_q + 8'd1;
        end
        // A hit outranks a simultaneous pause request.
        if (nave_atingida) begin
          if (vidas_q > 2'd1) begin
            vidas_d   = vidas_q - 2'd1;
            state_d   = StRestart;
            rst_cnt_d = '0;
          end else begin
            vidas_d = '0;
            state_d = StGameOver;
          end
        end else if (pause_edge) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_edge) begin
          state_d = StPlay;
        end else if (start_edge) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      fire_cnt_q <= '0;
      rst_cnt_q  <= '0;
      vidas_q    <= '0;
      pontos_q   <= '0;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      vivo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fire_cnt_q <= fire_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      vidas_q    <= vidas_d;
      pontos_q   <= pontos_d;
      start_q    <= btn_start;
      pause_q    <= btn_pause;
      vivo_q     <= inimigo_vivo;
    end
  end

  assign pausa           = (state_q != StPlay);
  assign reiniciarJogo   = (state_q == StRestart);
  assign game_tick       = tick_q;
  assign disparo_inimigo = fire_now;
  assign vidas           = vidas_q;
  assign pontos          = pontos_q;
  assign estado          = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: an abstract game model checked every cycle, plus directed
// scenarios with hand-derived expectations for ticks, restart, firing, lives, score and reset.
module tb_game_controller;

  localparam int TD = 4;
  localparam int LI = 3;
  localparam int FP = 3;
  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start, btn_pause, inimigo_vivo, nave_atingida;
  logic       pausa, reiniciarJogo, game_tick, disparo_inimigo;
  logic [1:0] vidas;
  logic [7:0] pontos;
  logic [2:0] estado;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses[$];
  int pause_p, pause_r;

  game_controller #(
    .TICK_DIV   (TD),
    .LIVES_INIT (LI),
    .FIRE_PERIOD(FP),
    .RESTART_LEN(RL)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .btn_start      (btn_start),
    .btn_pause      (btn_pause),
    .inimigo_vivo   (inimigo_vivo),
    .nave_atingida  (nave_atingida),
    .pausa          (pausa),
    .reiniciarJogo  (reiniciarJogo),
    .game_tick      (game_tick),
    .disparo_inimigo(disparo_inimigo),
    .vidas          (vidas),
    .pontos         (pontos),
    .estado         (estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: state as 0..4, restart as cycles remaining, ticks from edges since reset.
  int m_state = 0, m_vidas = 0, m_pontos = 0, m_edges = 0, m_rleft = 0, m_fire = 0;
  bit m_tick = 0, p_start = 0, p_pause = 0, p_vivo = 0;
  bit se, pe, vf;
  int ns;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_vidas = 0; m_pontos = 0; m_edges = 0; m_rleft = 0; m_fire = 0;
      m_tick = 0; p_start = 0; p_pause = 0; p_vivo = 0;
    end else begin
      se = btn_start && !p_start;
      pe = btn_pause && !p_pause;
      vf = !inimigo_vivo && p_vivo;
      ns = m_state;
      if (m_state == 0 || m_state == 4) begin
        if (se) begin
          ns = 1; m_rleft = RL; m_vidas = LI; m_pontos = 0;
        end
      end else if (m_state == 1) begin
        m_rleft = m_rleft - 1;
        if (m_rleft == 0) begin
          ns = 2; m_fire = 0;
        end
      end else if (m_state == 2) begin
        if (m_tick) m_fire = (m_fire == FP - 1) ? 0 : m_fire + 1;
        if (vf) m_pontos = (m_pontos < 255) ? m_pontos + 1 : 255;
        if (nave_atingida) begin
          if (m_vidas > 1) begin
            m_vidas = m_vidas - 1; ns = 1; m_rleft = RL;
          end else begin
            m_vidas = 0; ns = 4;
          end
        end else if (pe) begin
          ns = 3;
        end
      end else if (m_state == 3) begin
        if (pe) ns = 2;
        else if (se) ns = 0;
      end
      m_state = ns;
      m_edges = m_edges + 1;
      m_tick = (m_edges % TD) == 0;
      p_start = btn_start; p_pause = btn_pause; p_vivo = inimigo_vivo;
    end
  end

  bit exp_fire;
  always @(negedge clk) begin
    exp_fire = (m_state == 2) && m_tick && (m_fire == FP - 1) && (inimigo_vivo == 1'b1);
    check("cmp_estado", int'(estado), m_state);
    check("cmp_pausa", int'(pausa), int'(m_state != 2));
    check("cmp_reiniciar", int'(reiniciarJogo), int'(m_state == 1));
    check("cmp_tick", int'(game_tick), int'(m_tick));
    check("cmp_disparo", int'(disparo_inimigo), int'(exp_fire));
    check("cmp_vidas", int'(vidas), m_vidas);
    check("cmp_pontos", int'(pontos), m_pontos);
  end

  always @(negedge clk) if (disparo_inimigo) pulses.push_back(cyc);

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (int'(estado) != s && n < 20) begin
      tick_n(1);
      n++;
    end
    check(name, int'(estado), s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n12, n32, n_in, g;
    btn_start = 0; btn_pause = 0; inimigo_vivo = 0; nave_atingida = 0;
    #1 reset = 1'b0;
    tick_n(3);
    check("rst_estado", int'(estado), 0);
    check("rst_pausa", int'(pausa), 1);
    check("rst_vidas", int'(vidas), 0);
    check("rst_pontos", int'(pontos), 0);
    check("rst_tick", int'(game_tick), 0);
    reset = 1'b1;

    // game_tick after edges 4, 8, 12 only
    for (int k = 1; k <= 13; k++) begin
      tick_n(1);
      check($sformatf("tick_at_%0d", k), int'(game_tick), (k % 4 == 0) ? 1 : 0);
    end

    btn_start = 1; tick_n(1); btn_start = 0;
    for (int i = 0; i < 4; i++) begin
      check("restart_pulse", int'(reiniciarJogo), 1);
      tick_n(1);
    end
    check("play_estado", int'(estado), 2);
    check("play_pausa", int'(pausa), 0);
    check("play_reiniciar", int'(reiniciarJogo), 0);
    check("play_vidas", int'(vidas), 3);
    check("play_pontos", int'(pontos), 0);

    // Firing cadence with a 20-cycle pause
    inimigo_vivo = 1;
    pulses.delete();
    tick_n(40);
    btn_pause = 1; tick_n(1); btn_pause = 0; pause_p = cyc;
    check("pause_estado", int'(estado), 3);
    tick_n(19);
    btn_pause = 1; tick_n(1); btn_pause = 0; pause_r = cyc;
    check("resume_estado", int'(estado), 2);
    tick_n(30);
    n12 = 0; n32 = 0; n_in = 0;
    for (int i = 1; i < pulses.size(); i++) begin
      g = pulses[i] - pulses[i-1];
      if (g == 12) n12++;
      else if (g == 32) n32++;
    end
    foreach (pulses[i]) if (pulses[i] > pause_p && pulses[i] <= pause_r) n_in++;
    check("fire_count", pulses.size(), 6);
    check("fire_gap12", n12, 4);
    check("fire_gap32", n32, 1);
    check("fire_in_pause", n_in, 0);

    // Scoring then three hits
    inimigo_vivo = 0; tick_n(1); inimigo_vivo = 1; tick_n(1); inimigo_vivo = 0; tick_n(1);
    check("score_two", int'(pontos), 2);
    nave_atingida = 1; tick_n(1); nave_atingida = 0;
    check("hit1_vidas", int'(vidas), 2);
    check("hit1_estado", int'(estado), 1);
    wait_state(2, "hit1_play");
    nave_atingida = 1; tick_n(1); nave_atingida = 0;
    check("hit2_vidas", int'(vidas), 1);
    check("hit2_estado", int'(estado), 1);
    wait_state(2, "hit2_play");
    nave_atingida = 1; tick_n(1); nave_atingida = 0;
    check("hit3_vidas", int'(vidas), 0);
    check("hit3_estado", int'(estado), 4);
    check("hit3_pausa", int'(pausa), 1);
    check("hit3_pontos", int'(pontos), 2);

    // Events ignored outside PLAY
    inimigo_vivo = 1; tick_n(1); inimigo_vivo = 0; nave_atingida = 1; tick_n(1);
    nave_atingida = 0; tick_n(1);
    check("over_vidas", int'(vidas), 0);
    check("over_pontos", int'(pontos), 2);
    check("over_estado", int'(estado), 4);
    btn_start = 1; tick_n(1); btn_start = 0;
    check("again_estado", int'(estado), 1);
    check("again_vidas", int'(vidas), 3);
    check("again_pontos", int'(pontos), 0);
    wait_state(2, "again_play");

    // Hit + pause + enemy fall in one cycle
    inimigo_vivo = 1; tick_n(1);
    nave_atingida = 1; btn_pause = 1; inimigo_vivo = 0; tick_n(1);
    nave_atingida = 0; btn_pause = 0;
    check("simul_estado", int'(estado), 1);
    check("simul_vidas", int'(vidas), 2);
    check("simul_pontos", int'(pontos), 1);
    wait_state(2, "simul_play");
    for (int i = 0; i < 256; i++) begin
      inimigo_vivo = 1; tick_n(1);
      inimigo_vivo = 0; tick_n(1);
    end
    check("score_sat", int'(pontos), 255);

    // Asynchronous reset in the middle of RESTART
    nave_atingida = 1; tick_n(1); nave_atingida = 0;
    tick_n(1);
    check("mid_restart", int'(reiniciarJogo), 1);
    #1 reset = 1'b0;
    #1;
    check("async_reiniciar", int'(reiniciarJogo), 0);
    check("async_estado", int'(estado), 0);
    check("async_vidas", int'(vidas), 0);
    check("async_pontos", int'(pontos), 0);
    check("async_pausa", int'(pausa), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    tick_n(5);
    check("idle_wait", int'(estado), 0);
    btn_start = 1; tick_n(1); btn_start = 0;
    check("post_rst_estado", int'(estado), 1);
    check("post_rst_vidas", int'(vidas), 3);
    tick_n(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
